// File: rtl/instr_loader.sv
`timescale 1ns/1ps
// instr_loader: receives a length-prefixed, XOR-checksummed byte stream and writes
// the assembled 32-bit little-endian words into instruction memory, holding the core
// in reset (busy_o) until the program is loaded.
module instr_loader #(
  parameter int unsigned ADDRESS_WIDTH = 8,
  parameter int unsigned DATA_WIDTH    = 32,
  parameter int unsigned BASE_ADDR     = 0
) (
  input  logic                     clk_i,
  input  logic                     rst_n_i,
  input  logic                     start_i,
  input  logic [7:0]               byte_i,
  input  logic                     byte_valid_i,
  output logic                     byte_ready_o,
  output logic                     wr_en_o,
  output logic [ADDRESS_WIDTH-1:0] wr_addr_o,
  output logic [DATA_WIDTH-1:0]    wr_data_o,
  output logic                     busy_o,
  output logic                     done_o,
  output logic                     err_o,
  output logic [1:0]               err_code_o
);

  localparam int unsigned LEN_W     = 16;
  localparam int unsigned ASM_W     = DATA_WIDTH - 8;
  // Largest word count that fits between BASE_ADDR and the top of memory.
  localparam int unsigned MAX_WORDS = (32'd1 << (ADDRESS_WIDTH - 2)) - (BASE_ADDR / 4);

  localparam logic [1:0] ERR_NONE     = 2'b00;
  localparam logic [1:0] ERR_LENGTH   = 2'b01;
  localparam logic [1:0] ERR_CHECKSUM = 2'b10;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LEN_LO,
    S_LEN_HI,
    S_DATA,
    S_CHECK,
    S_DONE,
    S_ERROR
  } state_e;

  state_e                   state_q, state_d;
  logic [LEN_W-1:0]         len_q, len_d;
  logic [LEN_W-1:0]         idx_q, idx_d;
  logic [1:0]               bcnt_q, bcnt_d;
  logic [ASM_W-1:0]         asm_q, asm_d;
  logic [7:0]               cks_q, cks_d;
  logic                     wr_en_q, wr_en_d;
  logic [ADDRESS_WIDTH-1:0] wr_addr_q, wr_addr_d;
  logic [DATA_WIDTH-1:0]    wr_data_q, wr_data_d;
  logic                     busy_q, busy_d;
  logic                     ready_q, ready_d;
  logic                     done_q, done_d;
  logic                     err_q, err_d;
  logic [1:0]               err_code_q, err_code_d;

  logic                     xfer_c;
  logic [LEN_W-1:0]         len_full_c;

  assign xfer_c     = byte_valid_i & ready_q;
  assign len_full_c = {byte_i, len_q[7:0]};

  // Next-state, datapath and registered-output logic.
  always_comb begin
    state_d    = state_q;
    len_d      = len_q;
    idx_d      = idx_q;
    bcnt_d     = bcnt_q;
    asm_d      = asm_q;
    cks_d      = cks_q;
    wr_en_d    = 1'b0;
    wr_addr_d  = wr_addr_q;
    wr_data_d  = wr_data_q;
    done_d     = done_q;
    err_d      = err_q;
    err_code_d = err_code_q;

    case (state_q)
      S_IDLE, S_DONE, S_ERROR: begin
        if (start_i) begin
          state_d    = S_LEN_LO;
          done_d     = 1'b0;
          err_d      = 1'b0;
          err_code_d = ERR_NONE;
          cks_d      = 8'h00;
          idx_d      = '0;
          bcnt_d     = 2'd0;
        end
      end
      S_LEN_LO: begin
        if (xfer_c) begin
          len_d[7:0] = byte_i;
          state_d    = S_LEN_HI;
        end
      end
      S_LEN_HI: begin
        if (xfer_c) begin
          len_d = len_full_c;
          if (32'(len_full_c) > MAX_WORDS) begin
            state_d    = S_ERROR;
            err_d      = 1'b1;
            err_code_d = ERR_LENGTH;
          end else if (len_full_c == '0) begin
            state_d = S_CHECK;
          end else begin
            state_d = S_DATA;
          end
        end
      end
      S_DATA: begin
        if (xfer_c) begin
          cks_d  = cks_q ^ byte_i;
          bcnt_d = 2'(bcnt_q + 2'd1);
          case (bcnt_q)
            2'd0: asm_d[7:0]   = byte_i;
            2'd1: asm_d[15:8]  = byte_i;
            2'd2: asm_d[23:16] = byte_i;
            default: begin
              wr_en_d   = 1'b1;
              wr_data_d = {byte_i, asm_q};
              wr_addr_d = ADDRESS_WIDTH'(BASE_ADDR) + ADDRESS_WIDTH'({idx_q, 2'b00});
              idx_d     = LEN_W'(idx_q + 16'd1);
              if (LEN_W'(idx_q + 16'd1) == len_q) begin
                state_d = S_CHECK;
              end
            end
          endcase
        end
      end
      S_CHECK: begin
        if (xfer_c) begin
          if (byte_i == cks_q) begin
            state_d = S_DONE;
            done_d  = 1'b1;
          end else begin
            state_d    = S_ERROR;
            err_d      = 1'b1;
            err_code_d = ERR_CHECKSUM;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Stream handshake and core-hold both depend only on the (next) state.
    busy_d  = (state_d == S_LEN_LO) || (state_d == S_LEN_HI) ||
              (state_d == S_DATA)   || (state_d == S_CHECK);
    ready_d = busy_d;
  end

  // State and datapath registers; reset drops any pending write pulse.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q    <= S_IDLE;
      len_q      <= '0;
      idx_q      <= '0;
      bcnt_q     <= 2'd0;
      asm_q      <= '0;
      cks_q      <= 8'h00;
      wr_en_q    <= 1'b0;
      wr_addr_q  <= '0;
      wr_data_q  <= '0;
      busy_q     <= 1'b0;
      ready_q    <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      err_code_q <= ERR_NONE;
    end else begin
      state_q    <= state_d;
      len_q      <= len_d;
      idx_q      <= idx_d;
      bcnt_q     <= bcnt_d;
      asm_q      <= asm_d;
      cks_q      <= cks_d;
      wr_en_q    <= wr_en_d;
      wr_addr_q  <= wr_addr_d;
      wr_data_q  <= wr_data_d;
      busy_q     <= busy_d;
      ready_q    <= ready_d;
      done_q     <= done_d;
      err_q      <= err_d;
      err_code_q <= err_code_d;
    end
  end

  assign byte_ready_o = ready_q;
  assign wr_en_o      = wr_en_q;
  assign wr_addr_o    = wr_addr_q;
  assign wr_data_o    = wr_data_q;
  assign busy_o       = busy_q;
  assign done_o       = done_q;
  assign err_o        = err_q;
  assign err_code_o   = err_code_q;

endmodule

// File: tb/tb_instr_loader.sv
`timescale 1ns/1ps
// Scoreboard bench for instr_loader: stimulus pushes expected memory writes,
// a negedge monitor pops and compares every wr_en_o pulse.
module tb_instr_loader;

  localparam int unsigned AW = 8;
  localparam int unsigned DW = 32;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic [7:0]    bdata = 8'h00;
  logic          bvalid = 1'b0;
  logic          byte_ready_o;
  logic          wr_en_o;
  logic [AW-1:0] wr_addr_o;
  logic [DW-1:0] wr_data_o;
  logic          busy_o;
  logic          done_o;
  logic          err_o;
  logic [1:0]    err_code_o;

  always #5 clk = ~clk;

  instr_loader #(.ADDRESS_WIDTH(AW), .DATA_WIDTH(DW), .BASE_ADDR(0)) dut (
    .clk_i        (clk),
    .rst_n_i      (rst_n),
    .start_i      (start),
    .byte_i       (bdata),
    .byte_valid_i (bvalid),
    .byte_ready_o (byte_ready_o),
    .wr_en_o      (wr_en_o),
    .wr_addr_o    (wr_addr_o),
    .wr_data_o    (wr_data_o),
    .busy_o       (busy_o),
    .done_o       (done_o),
    .err_o        (err_o),
    .err_code_o   (err_code_o)
  );

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } wr_t;

  wr_t         exp_q[$];
  logic [31:0] prog[$];
  int          n_pass  = 0;
  int          n_total = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  // Monitor: every write pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    wr_t e;
    if (rst_n && wr_en_o) begin
      if (exp_q.size() == 0) begin
        n_total++;
        $display("FAIL unexpected_write: got 0x%0h@0x%0h expected none", wr_data_o, wr_addr_o);
      end else begin
        e = exp_q.pop_front();
        chk("wr_addr", 32'(wr_addr_o), 32'(e.addr));
        chk("wr_data", wr_data_o, e.data);
      end
    end
  end

  // Called at a negedge; returns at the negedge following the accepting edge.
  task automatic send(input logic [7:0] b, input bit rnd);
    int t;
    bit acc;
    if (rnd) begin
      while ($urandom_range(0, 1) == 0) begin
        bvalid = 1'b0;
        @(negedge clk);
      end
    end
    bdata  = b;
    bvalid = 1'b1;
    acc    = 1'b0;
    t      = 0;
    while (!acc && t < 100) begin
      acc = byte_ready_o;
      @(negedge clk);
      t++;
    end
    bvalid = 1'b0;
    if (!acc) begin
      n_total++;
      $display("FAIL send_timeout: byte 0x%0h not accepted, expected acceptance", b);
    end
  endtask

  task automatic start_session();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic load(input logic [15:0] n, input int nw, input logic [7:0] cks,
                      input bit rnd, input bit send_cks);
    logic [31:0] w;
    start_session();
    send(n[7:0], rnd);
    send(n[15:8], rnd);
    for (int i = 0; i < nw; i++) begin
      w = prog[i];
      exp_q.push_back({AW'(4 * i), w});
      send(w[7:0], rnd);
      send(w[15:8], rnd);
      send(w[23:16], rnd);
      send(w[31:24], rnd);
    end
    if (send_cks) send(cks, rnd);
    @(negedge clk);
  endtask

  task automatic result(input string tag, input logic d, input logic e, input logic [1:0] c);
    chk({tag, "_done"}, 32'(done_o), 32'(d));
    chk({tag, "_err"}, 32'(err_o), 32'(e));
    chk({tag, "_code"}, 32'(err_code_o), 32'(c));
    chk({tag, "_busy"}, 32'(busy_o), 32'd0);
    chk({tag, "_pending"}, 32'(exp_q.size()), 32'd0);
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_ready"}, 32'(byte_ready_o), 32'd0);
    chk({tag, "_wr_en"}, 32'(wr_en_o), 32'd0);
    chk({tag, "_wr_addr"}, 32'(wr_addr_o), 32'd0);
    chk({tag, "_wr_data"}, wr_data_o, 32'd0);
    chk({tag, "_busy"}, 32'(busy_o), 32'd0);
    chk({tag, "_done"}, 32'(done_o), 32'd0);
    chk({tag, "_err"}, 32'(err_o), 32'd0);
    chk({tag, "_code"}, 32'(err_code_o), 32'd0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] cks64;
    logic [7:0] iv;

    // Reset state
    #3;
    check_all_zero("reset");
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("idle_ready", 32'(byte_ready_o), 32'd0);
    chk("idle_busy", 32'(busy_o), 32'd0);

    // Test 1: two words; XOR of the eight data bytes is 0x35
    prog = '{32'h00A00513, 32'h00150593};
    load(16'd2, 2, 8'h35, 1'b0, 1'b1);
    result("t1", 1'b1, 1'b0, 2'b00);
    chk("t1_last_addr", 32'(wr_addr_o), 32'h04);
    chk("t1_last_data_held", wr_data_o, 32'h00150593);

    // Test 2: same stream, bad checksum
    load(16'd2, 2, 8'h3F, 1'b0, 1'b1);
    result("t2", 1'b0, 1'b1, 2'b10);

    // Test 3a: length one past capacity, rejected right after the length header
    load(16'h0041, 0, 8'h00, 1'b0, 1'b0);
    result("t3a", 1'b0, 1'b1, 2'b01);
    chk("t3a_ready", 32'(byte_ready_o), 32'd0);

    // Test 3b: maximal load fills memory up to 0xFC
    prog.delete();
    cks64 = 8'h00;
    for (int i = 0; i < 64; i++) begin
      iv = 8'(i);
      prog.push_back({~iv, 8'hC3, iv ^ 8'h5A, iv});
      cks64 = cks64 ^ (~iv) ^ 8'hC3 ^ (iv ^ 8'h5A) ^ iv;
    end
    load(16'h0040, 64, cks64, 1'b0, 1'b1);
    result("t3b", 1'b1, 1'b0, 2'b00);
    chk("t3b_top_addr", 32'(wr_addr_o), 32'hFC);

    // Test 4: empty programs
    load(16'h0000, 0, 8'h00, 1'b0, 1'b1);
    result("t4a", 1'b1, 1'b0, 2'b00);
    load(16'h0000, 0, 8'h01, 1'b0, 1'b1);
    result("t4b", 1'b0, 1'b1, 2'b10);

    // Test 5: test 1 with random valid gaps
    prog = '{32'h00A00513, 32'h00150593};
    load(16'd2, 2, 8'h35, 1'b1, 1'b1);
    result("t5", 1'b1, 1'b0, 2'b00);

    // Test 6: reset after five data bytes leaves exactly one write
    start_session();
    exp_q.push_back({AW'(0), 32'h00A00513});
    send(8'h02, 1'b0);
    send(8'h00, 1'b0);
    send(8'h13, 1'b0);
    send(8'h05, 1'b0);
    send(8'hA0, 1'b0);
    send(8'h00, 1'b0);
    send(8'h93, 1'b0);
    chk("t6_busy_before_reset", 32'(busy_o), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check_all_zero("t6_async");
    chk("t6_pending", 32'(exp_q.size()), 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    load(16'd2, 2, 8'h35, 1'b0, 1'b1);
    result("t6_restart", 1'b1, 1'b0, 2'b00);

    repeat (3) @(negedge clk);
    chk("final_pending", 32'(exp_q.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
